branch_ctrl: RTL and testbench

- Branch resolution and redirect controller for the pipelined RV32I core. Sits at the EX stage next to the branch comparator.
- Consumes the comparator's br_en, the decoded branch/jump type and the PC that fetch actually followed. Decides whether the core mispredicted, then issues a registered redirect and a multi-cycle flush.
- Owns a direction predictor (2-bit counter branch history table) that fetch reads combinationally and EX updates on resolution. Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_ctrl.sv | 167 ++++++++++++++++
 tb/tb_branch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution / redirect controller for the EX stage, with a 2-bit-counter
// direction predictor read by fetch and saturating branch/mispredict statistics.
module branch_ctrl #(
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_br,
  input  logic             ex_jmp,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic [31:0]      ex_pred_pc,
  input  logic             br_en,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int unsigned BhtEntries = 1 << BHT_IDX_BITS;
  localparam int unsigned FcntW      = $clog2(FLUSH_CYCLES + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  localparam logic [FcntW-1:0] FlushInit = FcntW'(FLUSH_CYCLES);
  localparam logic [FcntW-1:0] FcntOne   = FcntW'(1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  logic [0:0]       state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             redirect_q, redirect_d;
  logic [31:0]      rpc_q, rpc_d;
  logic             flush_q, flush_d;
  logic [CNT_W-1:0] brc_q, brc_d;
  logic [CNT_W-1:0] misc_q, misc_d;

  logic [1:0] bht_q [BhtEntries];
  logic [1:0] bht_cur, bht_nxt;

  logic [BHT_IDX_BITS-1:0] ex_idx, if_idx;

  logic        resolve, taken, mispredict, bht_upd;
  logic [31:0] pc_plus4, actual_pc;

  // Only the word-index bits of the fetch PC address the table.
  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[31:BHT_IDX_BITS+2], if_pc[1:0]};

  assign ex_idx = ex_pc[BHT_IDX_BITS+1:2];
  assign if_idx = if_pc[BHT_IDX_BITS+1:2];

  // EX content during FLUSH is wrong-path, so nothing resolves there.
  assign resolve    = (state_q == StIdle) & ex_valid & (ex_br | ex_jmp) & ~stall;
  assign taken      = ex_jmp | (ex_br & br_en);
  assign pc_plus4   = ex_pc + 32'd4;
  assign actual_pc  = taken ? ex_target : pc_plus4;
  assign mispredict = resolve & (actual_pc != ex_pred_pc);
  assign bht_upd    = resolve & ex_br;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    redirect_d = redirect_q;
    rpc_d      = rpc_q;
    flush_d    = flush_q;
    case (state_q)
      StIdle: begin
        if (mispredict) begin
          state_d    = StFlush;
          fcnt_d     = FlushInit;
          redirect_d = 1'b1;
          rpc_d      = actual_pc;
          flush_d    = 1'b1;
        end
      end
      StFlush: begin
        // Fetch consumes the redirect on the first unstalled cycle.
        if (!stall) begin
          redirect_d = 1'b0;
          fcnt_d     = fcnt_q - FcntOne;
          if (fcnt_q == FcntOne) begin
            state_d = StIdle;
            flush_d = 1'b0;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        fcnt_d     = '0;
        redirect_d = 1'b0;
        flush_d    = 1'b0;
      end
    endcase
  end

  always_comb begin
    brc_d  = brc_q;
    misc_d = misc_q;
    if (bht_upd && (brc_q != '1)) begin
      brc_d = brc_q + CntOne;
    end
    if (mispredict && (misc_q != '1)) begin
      misc_d = misc_q + CntOne;
    end
  end

  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_nxt = bht_cur;
    if (taken) begin
      if (bht_cur != 2'b11) begin
        bht_nxt = bht_cur + 2'd1;
      end
    end else begin
      if (bht_cur != 2'b00) begin
        bht_nxt = bht_cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fcnt_q     <= '0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      flush_q    <= 1'b0;
      brc_q      <= '0;
      misc_q     <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      flush_q    <= flush_d;
      brc_q      <= brc_d;
      misc_q     <= misc_d;
    end
  end

  // Table resets to weakly not-taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BhtEntries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      bht_q[ex_idx] <= bht_nxt;
    end
  end

  assign if_pred_taken = bht_q[if_idx][1];
  assign redirect      = redirect_q;
  assign redirect_pc   = rpc_q;
  assign flush         = flush_q;
  assign br_count      = brc_q;
  assign mispred_count = misc_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model (pending-flush budget, per-index counters).
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, ex_valid, ex_br, ex_jmp, br_en;
  logic [31:0] ex_pc, ex_target, ex_pred_pc, if_pc;

  logic        pred_a, redir_a, flush_a;
  logic [31:0] rpc_a, brc_a, mis_a;
  logic        pred_b, redir_b, flush_b;
  logic [31:0] rpc_b;
  logic [3:0]  brc_b, mis_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_left;   // unstalled cycles of flush still owed
  bit          m_redir;
  logic [31:0] m_rpc;
  int          m_br, m_mis;
  int          m_bht [64];

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_br(ex_br),
    .ex_jmp(ex_jmp), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_pc(ex_pred_pc),
    .br_en(br_en), .if_pc(if_pc), .if_pred_taken(pred_a), .redirect(redir_a),
    .redirect_pc(rpc_a), .flush(flush_a), .br_count(brc_a), .mispred_count(mis_a)
  );

  branch_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_br(ex_br),
    .ex_jmp(ex_jmp), .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_pc(ex_pred_pc),
    .br_en(br_en), .if_pc(if_pc), .if_pred_taken(pred_b), .redirect(redir_b),
    .redirect_pc(rpc_b), .flush(flush_b), .br_count(brc_b), .mispred_count(mis_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_left  = 0;
    m_redir = 0;
    m_rpc   = '0;
    m_br    = 0;
    m_mis   = 0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
  endtask

  task automatic check_outputs();
    check("redirect", {31'b0, redir_a}, {31'b0, m_redir});
    check("redirect_pc", rpc_a, m_rpc);
    check("flush", {31'b0, flush_a}, {31'b0, m_left > 0});
    check("br_count", brc_a, m_br);
    check("mispred_count", mis_a, m_mis);
    check("redirect4", {31'b0, redir_b}, {31'b0, m_redir});
    check("flush4", {31'b0, flush_b}, {31'b0, m_left > 0});
    check("br_count4", {28'b0, brc_b}, sat4(m_br));
    check("mispred_count4", {28'b0, mis_b}, sat4(m_mis));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] actual;
    bit          tk;
    int          idx;
    if (m_left == 0) begin
      if (ex_valid && (ex_br || ex_jmp) && !stall) begin
        tk     = ex_jmp || (ex_br && br_en);
        actual = tk ? ex_target : ex_pc + 32'd4;
        idx    = int'((ex_pc >> 2) & 32'h3f);
        if (ex_br) begin
          m_br++;
          m_bht[idx] = tk ? ((m_bht[idx] == 3) ? 3 : m_bht[idx] + 1)
                          : ((m_bht[idx] == 0) ? 0 : m_bht[idx] - 1);
        end
        if (actual != ex_pred_pc) begin
          m_mis++;
          m_left  = 2;
          m_redir = 1;
          m_rpc   = actual;
        end
      end
    end else if (!stall) begin
      m_redir = 0;
      m_left--;
    end
  endtask

  task automatic cycle();
    int idx;
    #3;
    idx = int'((if_pc >> 2) & 32'h3f);
    check("if_pred_taken", {31'b0, pred_a}, {31'b0, m_bht[idx] >= 2});
    check("if_pred_taken4", {31'b0, pred_b}, {31'b0, m_bht[idx] >= 2});
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v, input bit b, input bit j, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic [31:0] pred, input bit en,
                       input bit st, input logic [31:0] ipc);
    ex_valid = v; ex_br = b; ex_jmp = j; ex_pc = pc; ex_target = tgt;
    ex_pred_pc = pred; br_en = en; stall = st; if_pc = ipc;
    cycle();
  endtask

  task automatic idle(input int n, input logic [31:0] ipc);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, ipc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_flush", {31'b0, flush_a}, 32'd0);
    check("rst_redirect", {31'b0, redir_a}, 32'd0);
    check("rst_redirect_pc", rpc_a, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    logic [31:0] pc, tgt, pred;
    int kind;
    {stall, ex_valid, ex_br, ex_jmp, br_en} = '0;
    {ex_pc, ex_target, ex_pred_pc, if_pc} = '0;
    do_reset();

    // Reset prediction, then a taken branch predicted fall-through.
    idle(1, 32'h40);
    drive(1, 1, 0, 32'h100, 32'h80, 32'h104, 1, 0, 32'h100);
    idle(3, 32'h100);

    // Reset asserted while flushing.
    drive(1, 1, 0, 32'h100, 32'h80, 32'h104, 1, 0, 32'h100);
    do_reset();
    drive(1, 1, 0, 32'h100, 32'h80, 32'h104, 1, 0, 32'h100);
    idle(2, 32'h100);

    // Training the same entry up, then down to saturation.
    drive(1, 1, 0, 32'h100, 32'h80, 32'h80, 1, 0, 32'h100);
    idle(1, 32'h100);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 32'h100, 32'h80, 32'h104, 0, 0, 32'h100);
    idle(1, 32'h100);

    // Mispredict followed by 3 stalled cycles; wrong-path branch in EX is ignored.
    drive(1, 1, 0, 32'h200, 32'h300, 32'h204, 1, 0, 32'h240);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 32'h240, 32'h80, 32'h244, 1, 1, 32'h240);
    for (int i = 0; i < 2; i++) drive(1, 1, 0, 32'h240, 32'h80, 32'h244, 1, 0, 32'h240);
    idle(2, 32'h240);

    // PC wrap at the top of the address space.
    drive(1, 1, 0, 32'hFFFFFFFC, 32'h500, 32'h0, 0, 0, 32'hFFFFFFFC);
    drive(1, 0, 1, 32'hFFFFFFFC, 32'h200, 32'h0, 1, 0, 32'hFFFFFFFC);
    idle(3, 32'hFFFFFFFC);

    // 16 mispredicting jumps saturate the narrow counter.
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 1, 32'h10, 32'h400, 32'h14, 0, 0, 32'h10);
      idle(2, 32'h10);
    end
    check("mispred_sat4", {28'b0, mis_b}, 32'hF);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      pc = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 15) == 0) pc = 32'hFFFFFFFC;
      tgt  = $urandom & 32'hFFFFFFFC;
      kind = $urandom_range(0, 2);
      pred = (kind == 0) ? pc + 32'd4 : (kind == 1) ? tgt : ($urandom & 32'hFFFFFFFC);
      kind = $urandom_range(0, 3);
      drive($urandom_range(0, 9) < 7, kind == 1 || kind == 2, kind == 3, pc, tgt, pred,
            1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
            32'($urandom_range(0, 31)) << 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
